// File: rtl/uart_tx_fifo.sv
// UART transmitter with build-time framing (data bits, parity, stop bits) fed by a
// write FIFO so the host can burst words; frames go out LSB first.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 20833,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] STOP_LAST = CLK_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic             PAR_ODD   = (PARITY == 1);
    localparam logic             PAR_EN    = (PARITY != 0);

    // Elaboration-time parameter checks
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_par
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [CLK_W-1:0]       clk_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   tx_data;
    logic                   parity_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       cnt_next;
    logic [DATA_BITS-1:0]   head;
    logic                   push;
    logic                   pop;

    // Ready reflects the count before this cycle's pop, so a full FIFO never takes a write
    assign push = i_Tx_DV && o_Tx_Ready;
    assign pop  = (state == S_IDLE) && (o_Fifo_Count != '0);
    assign head = mem[rd_ptr];

    always_comb begin
        cnt_next = o_Fifo_Count;
        if (push && !pop) begin
            cnt_next = o_Fifo_Count + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_next = o_Fifo_Count - CNT_W'(1);
        end
    end

    // Storage array carries no reset; only the pointers and count define its contents
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_Fifo_Count <= '0;
            o_Tx_Ready   <= 1'b1;
            o_Overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_Fifo_Count <= cnt_next;
            o_Tx_Ready   <= (cnt_next != FULL_CNT);
            o_Overflow   <= i_Tx_DV && !o_Tx_Ready;
        end
    end

    // Line value is loaded on the edge entering each state, so every bit spans exactly CLKS_PER_BIT cycles
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            tx_data     <= '0;
            parity_bit  <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (pop) begin
                        tx_data     <= head;
                        parity_bit  <= PAR_ODD ? ~^head : ^head;
                        o_Tx_Active <= 1'b1;
                        o_Tx_Serial <= 1'b0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        o_Tx_Serial <= tx_data[0];
                        state       <= S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PAR_EN) begin
                                o_Tx_Serial <= parity_bit;
                                state       <= S_PARITY;
                            end else begin
                                o_Tx_Serial <= 1'b1;
                                state       <= S_STOP;
                            end
                        end else begin
                            bit_idx     <= bit_idx + IDX_W'(1);
                            tx_data     <= tx_data >> 1;
                            o_Tx_Serial <= tx_data[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                S_PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        o_Tx_Serial <= 1'b1;
                        state       <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == STOP_LAST) begin
                        clk_cnt     <= '0;
                        o_Tx_Serial <= 1'b1;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four framing variants at CLKS_PER_BIT=4, hand-computed line patterns.
module tb_uart_tx_fifo;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       dv_a, dv_b, dv_c, dv_d;
    logic [7:0] byte_a, byte_d;
    logic [6:0] byte_7;
    logic [3:0] ser_v, act_v, done_v, rdy_v, ovf_v;
    logic [4:0] cnt_a, cnt_b, cnt_c, cnt_d;

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst_a), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
        .o_Tx_Ready(rdy_v[0]), .o_Overflow(ovf_v[0]), .o_Fifo_Count(cnt_a),
        .o_Tx_Active(act_v[0]), .o_Tx_Serial(ser_v[0]), .o_Tx_Done(done_v[0])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2)) u_e7 (
        .i_Clock(clk), .i_Reset(rst_b), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_7),
        .o_Tx_Ready(rdy_v[1]), .o_Overflow(ovf_v[1]), .o_Fifo_Count(cnt_b),
        .o_Tx_Active(act_v[1]), .o_Tx_Serial(ser_v[1]), .o_Tx_Done(done_v[1])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1)) u_o7 (
        .i_Clock(clk), .i_Reset(rst_b), .i_Tx_DV(dv_c), .i_Tx_Byte(byte_7),
        .o_Tx_Ready(rdy_v[2]), .o_Overflow(ovf_v[2]), .o_Fifo_Count(cnt_c),
        .o_Tx_Active(act_v[2]), .o_Tx_Serial(ser_v[2]), .o_Tx_Done(done_v[2])
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_8n2 (
        .i_Clock(clk), .i_Reset(rst_b), .i_Tx_DV(dv_d), .i_Tx_Byte(byte_d),
        .o_Tx_Ready(rdy_v[3]), .o_Overflow(ovf_v[3]), .o_Fifo_Count(cnt_d),
        .o_Tx_Active(act_v[3]), .o_Tx_Serial(ser_v[3]), .o_Tx_Done(done_v[3])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Each frame bit (bit 0 = start) becomes CPB consecutive line samples
    function automatic logic [63:0] expand(input logic [15:0] bits, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n * int'(CPB); i++) v[i] = bits[i / int'(CPB)];
        return v;
    endfunction

    task automatic wait_low(input int budget, output bit ok);
        int i;
        i  = 0;
        ok = 1'b0;
        while (!ok && i < budget) begin
            if (ser_v[sel] === 1'b0) ok = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    // Called on the first START sample; returns on the first IDLE sample
    task automatic check_frame(input string tag, input int nbits, input logic [15:0] bits);
        logic [63:0] s, a;
        int nd;
        s = '0; a = '0; nd = 0;
        for (int i = 0; i < nbits * int'(CPB); i++) begin
            s[i] = ser_v[sel];
            a[i] = act_v[sel];
            if (done_v[sel] === 1'b1) nd++;
            @(negedge clk);
        end
        chk({tag, "_line"}, s, expand(bits, nbits));
        chk({tag, "_active"}, a, expand(16'hFFFF, nbits));
        chk({tag, "_early_done"}, 64'(nd), 64'd0);
        chk({tag, "_idle_ser"}, 64'(ser_v[sel]), 64'd1);
        chk({tag, "_idle_act"}, 64'(act_v[sel]), 64'd0);
        chk({tag, "_done"}, 64'(done_v[sel]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lows, dones;
        logic [7:0] b;

        rst_a = 1'b1; rst_b = 1'b1;
        dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0; dv_d = 1'b0;
        byte_a = '0; byte_d = '0; byte_7 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ser", 64'(ser_v[0]), 64'd1);
        chk("rst_act", 64'(act_v[0]), 64'd0);
        chk("rst_done", 64'(done_v[0]), 64'd0);
        chk("rst_ovf", 64'(ovf_v[0]), 64'd0);
        chk("rst_rdy", 64'(rdy_v[0]), 64'd1);
        chk("rst_cnt", 64'(cnt_a), 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        sel = 0;
        dv_a = 1'b1; byte_a = 8'hA5;
        @(negedge clk);
        dv_a = 1'b0;
        chk("t1_cnt", 64'(cnt_a), 64'd1);
        wait_low(20, ok);
        chk("t1_start", 64'(ok), 64'd1);
        check_frame("t1", 10, 16'h034A);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done_v[0]), 64'd0);
        chk("t1_cnt_end", 64'(cnt_a), 64'd0);

        // 7E1 and 7O1 of 0x03: parity 0 then 1
        sel = 1;
        dv_b = 1'b1; byte_7 = 7'h03;
        @(negedge clk);
        dv_b = 1'b0;
        wait_low(20, ok);
        chk("t2e_start", 64'(ok), 64'd1);
        check_frame("t2e", 10, 16'h0206);
        sel = 2;
        dv_c = 1'b1; byte_7 = 7'h03;
        @(negedge clk);
        dv_c = 1'b0;
        wait_low(20, ok);
        chk("t2o_start", 64'(ok), 64'd1);
        check_frame("t2o", 10, 16'h0306);

        // 8N2 0xFF: eight stop cycles high, then Active low and Done together
        sel = 3;
        dv_d = 1'b1; byte_d = 8'hFF;
        @(negedge clk);
        dv_d = 1'b0;
        wait_low(20, ok);
        chk("t4_start", 64'(ok), 64'd1);
        check_frame("t4", 11, 16'h07FE);
        @(negedge clk);
        chk("t4_done_pulse", 64'(done_v[3]), 64'd0);

        // Burst of 16 while a frame is on the line, 17th write overflows
        sel = 0;
        dv_a = 1'b1; byte_a = 8'h5A;
        @(negedge clk);
        dv_a = 1'b0;
        wait_low(20, ok);
        chk("t3_first_start", 64'(ok), 64'd1);
        for (int k = 0; k < 16; k++) begin
            dv_a = 1'b1; byte_a = 8'h10 + 8'(k);
            @(negedge clk);
        end
        chk("t3_full_cnt", 64'(cnt_a), 64'd16);
        chk("t3_full_rdy", 64'(rdy_v[0]), 64'd0);
        byte_a = 8'hEE;
        @(negedge clk);
        dv_a = 1'b0;
        chk("t3_ovf", 64'(ovf_v[0]), 64'd1);
        chk("t3_cnt_hold", 64'(cnt_a), 64'd16);
        @(negedge clk);
        chk("t3_ovf_pulse", 64'(ovf_v[0]), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (done_v[0] === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        chk("t3_first_done", 64'(ok), 64'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("t3_gap_start", 64'(ser_v[0]), 64'd0);
            b = 8'h10 + 8'(k);
            check_frame("t3", 10, {6'b0, 1'b1, b, 1'b0});
        end
        chk("t3_cnt_empty", 64'(cnt_a), 64'd0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser_v[0] !== 1'b1) lows++;
        end
        chk("t3_no_extra", 64'(lows), 64'd0);

        // Push and pop together at count 1
        dv_a = 1'b1; byte_a = 8'h3C;
        @(negedge clk);
        chk("t6_cnt1", 64'(cnt_a), 64'd1);
        byte_a = 8'hC3;
        @(negedge clk);
        dv_a = 1'b0;
        chk("t6_cnt_pushpop", 64'(cnt_a), 64'd1);
        chk("t6_start", 64'(ser_v[0]), 64'd0);
        check_frame("t6a", 10, {6'b0, 1'b1, 8'h3C, 1'b0});
        @(negedge clk);
        chk("t6_next_start", 64'(ser_v[0]), 64'd0);
        check_frame("t6b", 10, {6'b0, 1'b1, 8'hC3, 1'b0});
        chk("t6_cnt_end", 64'(cnt_a), 64'd0);

        // Reset during DATA bit 3 (line low there for 0xA5) with one word still queued
        dv_a = 1'b1; byte_a = 8'hA5;
        @(negedge clk);
        byte_a = 8'h77;
        @(negedge clk);
        dv_a = 1'b0;
        chk("t5_start", 64'(ser_v[0]), 64'd0);
        repeat (17) @(negedge clk);
        chk("t5_pre_ser", 64'(ser_v[0]), 64'd0);
        chk("t5_pre_cnt", 64'(cnt_a), 64'd1);
        rst_a = 1'b1;
        #1;
        chk("t5_rst_ser", 64'(ser_v[0]), 64'd1);
        chk("t5_rst_act", 64'(act_v[0]), 64'd0);
        chk("t5_rst_cnt", 64'(cnt_a), 64'd0);
        chk("t5_rst_rdy", 64'(rdy_v[0]), 64'd1);
        @(negedge clk);
        rst_a = 1'b0;
        lows = 0; dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (ser_v[0] !== 1'b1) lows++;
            if (done_v[0] !== 1'b0) dones++;
        end
        chk("t5_idle_line", 64'(lows), 64'd0);
        chk("t5_no_done", 64'(dones), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
